// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / 3-read register file with optional write-to-read
// bypass, per-register busy scoreboard and a post-reset zeroing sweep.
// The data array carries no reset; the sweep clears it instead.

// Per-read-port lane: bypass select, CLEAR-state forcing, busy gating.
module regfile_mp_rd #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter bit BYPASS        = 1
) (
  input  logic                     run,
  input  logic [ADDRESS_WIDTH-1:0] radd,
  input  logic [DATA_WIDTH-1:0]    stored,
  input  logic                     busy_bit,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] wadd0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] wadd1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic [DATA_WIDTH-1:0]    dt,
  output logic                     busy
);
  // Read data: stored value, overridden by the winning same-cycle write.
  always_comb begin
    dt = '0;
    if (run) begin
      dt = stored;
      if (BYPASS) begin
        if (we1 && wadd1 == radd)      dt = wdata1;
        else if (we0 && wadd0 == radd) dt = wdata0;
      end
    end
  end

  // Busy has no bypass; a same-cycle write still reports the old bit.
  assign busy = run & busy_bit;
endmodule

module regfile_mp #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter bit BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     xb_rf_w_En,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  input  logic [DATA_WIDTH-1:0]    xb_rf_dt,
  input  logic                     ld_rf_w_En,
  input  logic [ADDRESS_WIDTH-1:0] ld_rf_wadd,
  input  logic [DATA_WIDTH-1:0]    ld_rf_dt,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddz,
  input  logic                     ps_rf_lock_En,
  input  logic [ADDRESS_WIDTH-1:0] ps_rf_lock_add,
  input  logic                     ps_rf_clr,
  output logic [DATA_WIDTH-1:0]    rf_xb_dtx,
  output logic [DATA_WIDTH-1:0]    rf_xb_dty,
  output logic [DATA_WIDTH-1:0]    rf_xb_dtz,
  output logic                     rf_ps_busyx,
  output logic                     rf_ps_busyy,
  output logic                     rf_ps_busyz,
  output logic                     rf_ps_rdy
);
  localparam int DEPTH  = 2**ADDRESS_WIDTH;
  localparam int NUM_RD = 3;
  localparam logic [ADDRESS_WIDTH-1:0] LAST = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic                     rdy_q;
  logic [DEPTH-1:0]         busy, busy_nxt;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     run, we0, we1;

  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] radd;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_dt;
  logic [NUM_RD-1:0]                    rd_busy;

  assign run = (state == RUN);
  // A clear request drops same-cycle writes; ld wins an address collision.
  assign we1 = run && !ps_rf_clr && ld_rf_w_En;
  assign we0 = run && !ps_rf_clr && xb_rf_w_En &&
               !(ld_rf_w_En && ld_rf_wadd == ps_xb_wadd);

  // Sequencer: sweep every address once, then run until a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= RUN;
            rdy_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (ps_rf_clr) begin
            state <= CLEAR;
            cnt   <= '0;
            rdy_q <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rf_ps_rdy = rdy_q;

  // Storage: sweep zeroes one entry per cycle, otherwise the two write ports.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      if (we0) mem[ps_xb_wadd] <= xb_rf_dt;
      if (we1) mem[ld_rf_wadd] <= ld_rf_dt;
    end
  end

  // Scoreboard next state: writes retire a producer, a new lock wins over it.
  always_comb begin
    busy_nxt = busy;
    if (xb_rf_w_En)    busy_nxt[ps_xb_wadd]     = 1'b0;
    if (ld_rf_w_En)    busy_nxt[ld_rf_wadd]     = 1'b0;
    if (ps_rf_lock_En) busy_nxt[ps_rf_lock_add] = 1'b1;
  end

  // Scoreboard register: only tracks in RUN, wiped by reset and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                busy <= '0;
    else if (!run || ps_rf_clr) busy <= '0;
    else                       busy <= busy_nxt;
  end

  assign radd = {ps_xb_raddz, ps_xb_raddy, ps_xb_raddx};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rd #(
      .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .BYPASS(BYPASS)
    ) u_rd (
      .run     (run),
      .radd    (radd[i]),
      .stored  (mem[radd[i]]),
      .busy_bit(busy[radd[i]]),
      .we0     (we0),
      .wadd0   (ps_xb_wadd),
      .wdata0  (xb_rf_dt),
      .we1     (we1),
      .wadd1   (ld_rf_wadd),
      .wdata1  (ld_rf_dt),
      .dt      (rd_dt[i]),
      .busy    (rd_busy[i])
    );
  end

  assign rf_xb_dtx   = rd_dt[0];
  assign rf_xb_dty   = rd_dt[1];
  assign rf_xb_dtz   = rd_dt[2];
  assign rf_ps_busyx = rd_busy[0];
  assign rf_ps_busyy = rd_busy[1];
  assign rf_ps_busyz = rd_busy[2];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: BYPASS=1 and BYPASS=0 instances share stimulus; both are
// compared every cycle against an array/scoreboard reference model.
module tb_regfile_mp;
  localparam int DW = 16, AW = 4, DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          xb_en = 0, ld_en = 0, lock_en = 0, clr = 0;
  logic [AW-1:0] xb_a = 0, ld_a = 0, lock_a = 0, rx = 0, ry = 0, rz = 0;
  logic [DW-1:0] xb_d = 0, ld_d = 0;

  logic [DW-1:0] dx1, dy1, dz1, dx0, dy0, dz0;
  logic          bx1, by1, bz1, bx0, by0, bz0, rdy1, rdy0;

  regfile_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .xb_rf_w_En(xb_en), .ps_xb_wadd(xb_a), .xb_rf_dt(xb_d),
    .ld_rf_w_En(ld_en), .ld_rf_wadd(ld_a), .ld_rf_dt(ld_d),
    .ps_xb_raddx(rx), .ps_xb_raddy(ry), .ps_xb_raddz(rz),
    .ps_rf_lock_En(lock_en), .ps_rf_lock_add(lock_a), .ps_rf_clr(clr),
    .rf_xb_dtx(dx1), .rf_xb_dty(dy1), .rf_xb_dtz(dz1),
    .rf_ps_busyx(bx1), .rf_ps_busyy(by1), .rf_ps_busyz(bz1), .rf_ps_rdy(rdy1));

  regfile_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .xb_rf_w_En(xb_en), .ps_xb_wadd(xb_a), .xb_rf_dt(xb_d),
    .ld_rf_w_En(ld_en), .ld_rf_wadd(ld_a), .ld_rf_dt(ld_d),
    .ps_xb_raddx(rx), .ps_xb_raddy(ry), .ps_xb_raddz(rz),
    .ps_rf_lock_En(lock_en), .ps_rf_lock_add(lock_a), .ps_rf_clr(clr),
    .rf_xb_dtx(dx0), .rf_xb_dty(dy0), .rf_xb_dtz(dz0),
    .rf_ps_busyx(bx0), .rf_ps_busyy(by0), .rf_ps_busyz(bz0), .rf_ps_rdy(rdy0));

  int checks = 0, failures = 0;

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_rdy;
  int            m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_rdy  = 0;
    m_left = DEPTH;
    foreach (m_busy[i]) m_busy[i] = 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] r, input bit byp);
    if (!m_rdy) return '0;
    if (byp && !clr) begin
      if (ld_en && ld_a == r) return ld_d;
      if (xb_en && xb_a == r) return xb_d;
    end
    return m_mem[r];
  endfunction

  function automatic void m_update();
    if (!rst_n) begin
      m_reset();
    end else if (!m_rdy) begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else if (clr) begin
      m_reset();
    end else begin
      if (xb_en) begin m_mem[xb_a] = xb_d; m_busy[xb_a] = 0; end
      if (ld_en) begin m_mem[ld_a] = ld_d; m_busy[ld_a] = 0; end
      if (lock_en) m_busy[lock_a] = 1;
    end
  endfunction

  task automatic check_outs();
    logic [AW-1:0] ra [3];
    logic [DW-1:0] g1 [3], g0 [3];
    logic          b1 [3], b0 [3];
    string         nm [3];
    ra = '{rx, ry, rz};
    g1 = '{dx1, dy1, dz1};
    g0 = '{dx0, dy0, dz0};
    b1 = '{bx1, by1, bz1};
    b0 = '{bx0, by0, bz0};
    nm = '{"x", "y", "z"};
    chk("rdy_b1", 32'(rdy1), 32'(m_rdy));
    chk("rdy_b0", 32'(rdy0), 32'(m_rdy));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("dt%s_b1 a=%0d", nm[p], ra[p]), 32'(g1[p]), 32'(exp_rd(ra[p], 1)));
      chk($sformatf("dt%s_b0 a=%0d", nm[p], ra[p]), 32'(g0[p]), 32'(exp_rd(ra[p], 0)));
      chk($sformatf("busy%s_b1 a=%0d", nm[p], ra[p]), 32'(b1[p]), 32'(m_rdy && m_busy[ra[p]]));
      chk($sformatf("busy%s_b0 a=%0d", nm[p], ra[p]), 32'(b0[p]), 32'(m_rdy && m_busy[ra[p]]));
    end
  endtask

  // inputs change at negedge; outputs sampled 1 time unit later
  task automatic step();
    #1 check_outs();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    xb_en = 0; ld_en = 0; lock_en = 0; clr = 0;
  endtask

  task automatic rand_in(input int clr_pct);
    xb_en = $urandom_range(0, 1); ld_en = $urandom_range(0, 1);
    lock_en = ($urandom_range(0, 3) == 0);
    clr = ($urandom_range(0, 99) < clr_pct);
    xb_a = AW'($urandom); ld_a = AW'($urandom); lock_a = AW'($urandom);
    xb_d = DW'($urandom); ld_d = DW'($urandom);
    rx = ($urandom_range(0, 2) == 0) ? xb_a : AW'($urandom);
    ry = ($urandom_range(0, 2) == 0) ? ld_a : AW'($urandom);
    rz = ($urandom_range(0, 2) == 0) ? lock_a : AW'($urandom);
  endtask

  task automatic count_sweep(input string tag, input bit rnd);
    int n = 0;
    while (!rdy1 && n < 40) begin
      if (rnd) rand_in(0); else idle();
      step();
      n++;
    end
    idle();
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1 chk("reset_rdy", 32'(rdy1), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // 1: sweep length, then everything reads zero
    count_sweep("sweep_len", 0);
    for (int i = 0; i < DEPTH; i++) begin
      rx = AW'(i); ry = AW'(i); rz = AW'(DEPTH - 1 - i);
      step();
    end

    // 2: bypass vs no-bypass on xb write
    xb_en = 1; xb_a = 3; xb_d = 16'hBEEF; rx = 3;
    step();
    idle(); step();
    chk("beef_stored", 32'(dx0), 32'h0000_BEEF);

    // 3: same-address collision, then split addresses
    xb_en = 1; xb_a = 5; xb_d = 16'h1111; ld_en = 1; ld_a = 5; ld_d = 16'h2222; ry = 5;
    step();
    idle(); step();
    xb_en = 1; xb_a = 5; xb_d = 16'h3333; ld_en = 1; ld_a = 6; ld_d = 16'h4444; rz = 6;
    step();
    idle(); step();

    // 4: scoreboard lock / retire / lock+write
    lock_en = 1; lock_a = 7; rz = 7; step();
    idle(); step();
    ld_en = 1; ld_a = 7; ld_d = 16'h0707; step();
    idle(); step();
    lock_en = 1; lock_a = 7; ld_en = 1; ld_a = 7; ld_d = 16'h7777; step();
    idle(); step();
    chk("lock_wins", 32'(bz1), 32'd1);

    // 5: clear request outranks a same-cycle write
    xb_en = 1; xb_a = 2; xb_d = 16'hAAAA; lock_en = 1; lock_a = 9; step();
    idle(); clr = 1; xb_en = 1; xb_a = 4; xb_d = 16'h5555; rx = 2; ry = 4; rz = 9;
    step();
    count_sweep("clr_sweep_len", 0);
    rx = 2; ry = 4; rz = 9; step();

    // 6: reset mid-sweep restarts from zero; sweep writes are ignored
    idle(); clr = 1; step();
    for (int i = 0; i < 8; i++) begin rand_in(0); step(); end
    rst_n = 0; m_reset();
    #1 chk("midsweep_rst_rdy", 32'(rdy1), 32'd0);
    idle(); step(); step();
    rst_n = 1;
    count_sweep("restart_sweep_len", 1);
    for (int i = 0; i < DEPTH; i++) begin
      rx = AW'(i); ry = AW'(i); rz = AW'(i);
      step();
    end

    // random traffic, occasional clears and a mid-run reset
    for (int c = 0; c < 600; c++) begin
      rand_in(2);
      if (c == 300) begin
        rst_n = 0; m_reset();
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port, parametrised successor to the control-unit register file. Two write ports (crossbar result path plus load path) and three combinational read ports (x, y, z).
- Adds optional write-to-read bypass and a per-register busy scoreboard for the sequencer's hazard checks.
- Clears the array with a post-reset sweep, so the storage array itself needs no reset and stays RAM-inferable.

Parameters:
DATA_WIDTH, 16, width of each register
ADDRESS_WIDTH, 4, register address width; depth = 2**ADDRESS_WIDTH
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
xb_rf_w_En  in  1  write enable, port 0 (crossbar)
ps_xb_wadd  in  ADDRESS_WIDTH  write address, port 0
xb_rf_dt  in  DATA_WIDTH  write data, port 0
ld_rf_w_En  in  1  write enable, port 1 (load path)
ld_rf_wadd  in  ADDRESS_WIDTH  write address, port 1
ld_rf_dt  in  DATA_WIDTH  write data, port 1
ps_xb_raddx  in  ADDRESS_WIDTH  read address x
ps_xb_raddy  in  ADDRESS_WIDTH  read address y
ps_xb_raddz  in  ADDRESS_WIDTH  read address z
ps_rf_lock_En  in  1  mark register busy (pending producer)
ps_rf_lock_add  in  ADDRESS_WIDTH  register to mark busy
ps_rf_clr  in  1  synchronous request to re-run the clear sweep
rf_xb_dtx  out  DATA_WIDTH  read data x
rf_xb_dty  out  DATA_WIDTH  read data y
rf_xb_dtz  out  DATA_WIDTH  read data z
rf_ps_busyx  out  1  busy bit of raddx
rf_ps_busyy  out  1  busy bit of raddy
rf_ps_busyz  out  1  busy bit of raddz
rf_ps_rdy  out  1  high when the clear sweep is done and the file is usable

Behaviour:
- FSM states: CLEAR, RUN.
- Reset (rst_n low, async): state=CLEAR, sweep counter=0, all busy bits=0, rf_ps_rdy=0. The data array is not reset.
- CLEAR state:
  - Each cycle writes 0 to regfile[counter], then counter+1.
  - Write to address 2**ADDRESS_WIDTH-1 → next cycle state=RUN, rf_ps_rdy=1. Sweep takes exactly 2**ADDRESS_WIDTH cycles after rst_n deasserts.
  - Both write ports and lock requests are ignored.
  - All read data outputs are forced to 0; all busy outputs are 0.
- RUN state:
  - ps_rf_clr=1 → next cycle state=CLEAR, counter=0, rf_ps_rdy=0, all busy bits cleared.
  - A clear request outranks writes and locks in the same cycle; those writes are dropped.
- Writes in RUN:
  - Registered on the rising edge.
  - Both ports enabled to the same address → port 1 (ld) wins. Port 0 is dropped for that address.
  - Different addresses → both are written.
- Reads: combinational, zero latency.
  - BYPASS=1 and the read address matches an enabled write address this cycle → output the winning write data (port 1 over port 0).
  - Otherwise output the stored value.
  - BYPASS=0 → always the stored value; new data is visible the cycle after the write.
- Scoreboard (RUN only):
  - ps_rf_lock_En sets busy[lock_add] at the clock edge.
  - Any write (either port) clears busy[wadd].
  - Lock and write to the same address in one cycle → lock wins (busy=1, because the new producer is pending).
  - A lock to an already-busy register keeps it at 1.
- Busy outputs: rf_ps_busy{x,y,z} = busy[radd]. They are combinational with no bypass: a same-cycle write still shows busy=1 that cycle.
- rst_n asserted mid-sweep or mid-run → immediate return to CLEAR with counter=0. The sweep restarts from address 0.
- Counter is ADDRESS_WIDTH+1 bits or uses a terminal compare; it must never wrap into RUN early.

Test Plan:
1. Release rst_n; count cycles until rf_ps_rdy=1 → exactly 16 (ADDRESS_WIDTH=4). Then read all 16 addresses on x/y/z → every value 0x0000.
2. RUN, BYPASS=1: write xb port addr 3 = 0xBEEF with raddx=3 in the same cycle → rf_xb_dtx=0xBEEF that cycle. With BYPASS=0 it stays 0x0000 until the next cycle, then reads 0xBEEF.
3. Both ports write addr 5 (xb 0x1111, ld 0x2222) → rf_xb_dty=0x2222 via bypass and stored 0x2222 afterwards. Repeat with addr 5 / addr 6 → both registers written.
4. Lock addr 7 → busyz=1 from the next cycle. ld write to addr 7 → busyz=0 after the edge. Lock plus write to addr 7 in the same cycle → busyz stays 1 and the data is written.
5. Mid-run: write 0xAAAA to addr 2 and lock addr 9, then pulse ps_rf_clr together with a write of 0x5555 to addr 4 → rf_ps_rdy drops; after 16 cycles rdy=1, addrs 2/4 read 0, busy of addr 9 = 0.
6. Assert rst_n low at sweep count 8, release → rf_ps_rdy rises exactly 16 cycles after release. Writes attempted during the sweep leave their registers at 0.
